// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first, through a
// single registered borrow stage, with valid/ready handshakes on input and output.
module serial_ripple_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d_bit;
  logic             w_borrow_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_a_bit       = r_a[0];
  assign w_b_bit       = r_b[0];
  assign w_d_bit       = w_a_bit ^ w_b_bit ^ r_borrow;
  assign w_borrow_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
  assign w_last        = (r_cnt == LAST);
  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_next    = (WIDTH'(w_d_bit) << (WIDTH - 1)) | (r_res >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      D        <= '0;
      Bout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_cnt    <= '0;
            r_res    <= '0;
          end
        end
        S_BUSY: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CW'(1);
          r_res    <= w_res_next;
          // Outputs update only here, so partial results never reach D.
          if (w_last) begin
            D    <= w_res_next;
            Bout <= w_borrow_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
